// File: rtl/datapath_pipe.sv
// Two-stage integer datapath: regfile + ALU issue stage, registered writeback stage.
// Build option DATAPATH_BYPASS_EN: forward wb_result to operands instead of stalling.
module datapath_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [3:0]      alu_control,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    input  logic            regwrite,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            zero_flag,
    output logic [31:0]     retired,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    logic [XLEN-1:0] rf_q [NREGS];

    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [AW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_result_q, wb_result_d;
    logic            zero_q, zero_d;
    logic [31:0]     retired_q, retired_d;

    logic            wb_commit;
    logic            rs1_hit, rs2_hit;
    logic            accept;
    logic [XLEN-1:0] rf_a, rf_b;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  sh;

    // The WB entry is both the pending regfile write and the hazard source.
    assign wb_commit = wb_valid_q && wb_we_q && (wb_rd_q != '0);
    assign rs1_hit   = wb_commit && (rs1 == wb_rd_q);
    assign rs2_hit   = wb_commit && !use_imm && (rs2 == wb_rd_q);

    assign rf_a = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rf_b = (rs2 == '0) ? '0 : rf_q[rs2];

`ifdef DATAPATH_BYPASS_EN
    always_comb begin
        op_a     = rs1_hit ? wb_result_q : rf_a;
        op_b     = use_imm ? imm : (rs2_hit ? wb_result_q : rf_b);
        in_ready = reset;
    end
`else
    // Without forwarding, a dependent instruction waits one cycle for the write to land.
    always_comb begin
        op_a     = rf_a;
        op_b     = use_imm ? imm : rf_b;
        in_ready = reset && !(rs1_hit || rs2_hit);
    end
`endif

    assign accept = in_valid && in_ready;
    assign sh     = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_control)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << sh;
            ALU_SRL:  alu_res = op_a >> sh;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> sh);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        wb_valid_d  = accept;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        zero_d      = zero_q;
        retired_d   = retired_q + {31'd0, wb_valid_q};
        if (accept) begin
            wb_we_d     = regwrite;
            wb_rd_d     = rd;
            wb_result_d = alu_res;
            zero_d      = (alu_res == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            zero_q      <= 1'b0;
            retired_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            zero_q      <= zero_d;
            retired_q   <= retired_d;
            if (wb_commit) begin
                rf_q[wb_rd_q] <= wb_result_q;
            end
        end
    end

    assign out_valid  = wb_valid_q;
    assign out_result = wb_result_q;
    assign zero_flag  = zero_q;
    assign retired    = retired_q;
    assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed cases with literal expectations plus random
// traffic checked every cycle against an architectural (in-order) model.
`timescale 1ns/1ps
module tb_datapath_pipe;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef DATAPATH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
    logic [3:0]      alu_control = 4'd0;
    logic            use_imm = 1'b0, regwrite = 1'b0;
    logic [XLEN-1:0] imm = '0;
    logic            out_valid, zero_flag;
    logic [XLEN-1:0] out_result, dbg_data;
    logic [31:0]     retired;

    datapath_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control), .use_imm(use_imm),
        .imm(imm), .regwrite(regwrite), .out_valid(out_valid), .out_result(out_result),
        .zero_flag(zero_flag), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Architectural model: register array, last completed instruction, counters.
    logic [XLEN-1:0] m_reg [NREGS];
    bit              p_valid, p_we;
    logic [AW-1:0]   p_rd;
    logic [XLEN-1:0] p_res;
    bit              m_ov, m_zero;
    logic [XLEN-1:0] m_res;
    logic [31:0]     m_ret;
    bit              chk_en = 1'b0;

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b % XLEN);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return XLEN'($signed(a) >>> sh);
            4'd7:    return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd10:   return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic bit ref_ready();
        bit hz;
        if (!reset) return 1'b0;
        if (BYP != 0) return 1'b1;
        hz = p_valid && p_we && (p_rd != 0) && ((rs1 == p_rd) || (!use_imm && (rs2 == p_rd)));
        return !hz;
    endfunction

    always @(posedge clock) begin : model
        bit acc;
        logic [XLEN-1:0] a, b, r;
        acc = in_valid && ref_ready();
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
            p_valid = 0; p_we = 0; p_rd = '0; p_res = '0;
            m_ov = 0; m_zero = 0; m_res = '0; m_ret = '0;
        end else begin
            if (p_valid) begin
                m_ret = m_ret + 1;
                if (p_we && p_rd != 0) m_reg[p_rd] = p_res;
            end
            if (acc) begin
                a = m_reg[rs1];
                b = use_imm ? imm : m_reg[rs2];
                r = ref_alu(alu_control, a, b);
                p_valid = 1; p_we = regwrite; p_rd = rd; p_res = r;
                m_res = r; m_zero = (r == '0); m_ov = 1;
            end else begin
                p_valid = 0; m_ov = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", in_ready, ref_ready());
            chk("out_valid", out_valid, m_ov);
            chk("out_result", out_result, m_res);
            chk("zero_flag", zero_flag, m_zero);
            chk("retired", retired, m_ret);
            chk("dbg_data", dbg_data, m_reg[dbg_addr]);
        end
    end

    task automatic issue(input logic [AW-1:0] a_rs1, input logic [AW-1:0] a_rs2,
                         input logic [AW-1:0] a_rd, input logic [3:0] op, input bit ui,
                         input logic [XLEN-1:0] im, input bit rw, output int stalls);
        bit acc;
        acc = 0;
        stalls = 0;
        rs1 = a_rs1; rs2 = a_rs2; rd = a_rd; alu_control = op;
        use_imm = ui; imm = im; regwrite = rw; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            stalls++;
        end
        in_valid = 1'b0;
        chk("issue_accept", acc, 1);
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int s;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_in_ready_low", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int a = 0; a < NREGS; a++) begin
            dbg_addr = AW'(a);
            #0.25;
            chk("rst_dbg", dbg_data, 0);
        end
        dbg_addr = '0;
        @(negedge clock);
        chk("rst_in_ready_rel", in_ready, 1);
        chk("rst_retired", retired, 0);
        @(posedge clock);
        #1;

        // x1 = x0 + 5, then x2 = x1 - x1
        issue(0, 0, 1, 4'b0010, 1, 5, 1, s);
        chk("add_imm_res", out_result, 5);
        chk("add_imm_zero", zero_flag, 0);
        issue(1, 1, 2, 4'b0110, 0, 0, 1, s);
        chk("sub_stall", s, (BYP != 0) ? 0 : 1);
        chk("sub_res", out_result, 0);
        chk("sub_zero", zero_flag, 1);
        idle();
        chk("retired_2", retired, 2);

        // shifts and compares on x3 = 0x80000000
        issue(0, 0, 3, 4'b0010, 1, 32'h8000_0000, 1, s);
        issue(3, 0, 5, 4'b1001, 1, 4, 1, s);
        chk("sra_stall", s, (BYP != 0) ? 0 : 1);
        chk("sra4", out_result, 32'hF800_0000);
        issue(3, 0, 6, 4'b1000, 1, 4, 1, s);
        chk("srl4", out_result, 32'h0800_0000);
        issue(3, 0, 7, 4'b0111, 1, 1, 1, s);
        chk("slt", out_result, 1);
        issue(3, 0, 7, 4'b1010, 1, 1, 1, s);
        chk("sltu", out_result, 0);
        issue(3, 0, 8, 4'b1000, 1, 33, 1, s);
        chk("srl33", out_result, 32'h4000_0000);
        issue(3, 0, 8, 4'b1001, 1, 33, 1, s);
        chk("sra33", out_result, 32'hC000_0000);

        // x0 protection
        issue(0, 0, 0, 4'b0010, 1, 7, 1, s);
        chk("x0_write_res", out_result, 7);
        issue(0, 0, 8, 4'b0010, 0, 0, 1, s);
        chk("x0_read_stall", s, 0);
        chk("x0_read_res", out_result, 0);
        idle();
        dbg_addr = '0;
        #1;
        chk("x0_dbg", dbg_data, 0);

        // rs2 dependency ignored with use_imm
        issue(1, 0, 9, 4'b0010, 1, 1, 1, s);
        chk("x9_res", out_result, 6);
        issue(1, 9, 10, 4'b0010, 1, 2, 1, s);
        chk("imm_rs2_stall", s, 0);
        chk("imm_rs2_res", out_result, 7);

        for (int k = 0; k < 10; k++) begin
            issue(1, 0, 1, 4'b0010, 1, XLEN'(k), 0, s);
            chk("cnt_stall", s, 0);
        end
        idle();
        chk("retired_23", retired, 23);

        // reset while x4 = x0 + 9 is in writeback
        issue(0, 0, 4, 4'b0010, 1, 9, 1, s);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        dbg_addr = 4;
        #1;
        chk("midrst_dbg4", dbg_data, 0);
        chk("midrst_retired", retired, 0);
        idle();

        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            rs1         = AW'($urandom_range(0, 3));
            rs2         = AW'($urandom_range(0, 3));
            rd          = AW'($urandom_range(0, 3));
            alu_control = 4'($urandom_range(0, 15));
            use_imm     = $urandom_range(0, 1) != 0;
            imm         = ($urandom_range(0, 1) != 0) ? $urandom : XLEN'($urandom_range(0, 40));
            regwrite    = $urandom_range(0, 3) != 0;
            dbg_addr    = AW'($urandom_range(0, NREGS - 1));
            reset       = $urandom_range(0, 199) != 0;
            idle();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised two-stage integer datapath: a register file plus ALU with a registered writeback stage, immediate-operand mode, and a valid/ready issue handshake. It is the next generation of the single-cycle register-file/ALU datapath and sits between the decode logic and the register file in the core. Data hazards between back-to-back instructions are handled by forwarding or, when forwarding is compiled out, by stalling. A retire counter and a debug read port are added for bring-up.

## Interface
- XLEN, 32, data width; power of two, at least 8.
- NREGS, 32, number of architectural registers; power of two, at least 2. Derived localparam AW = $clog2(NREGS).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the instruction is accepted this cycle.
- rs1  in  AW  operand-A register.
- rs2  in  AW  operand-B register.
- rd  in  AW  destination register.
- alu_control  in  4  operation select.
- use_imm  in  1  operand B = imm instead of reg[rs2].
- imm  in  XLEN  immediate operand.
- regwrite  in  1  write the result to rd.
- out_valid  out  1  one-cycle pulse: out_result holds a completed instruction.
- out_result  out  XLEN  registered ALU result.
- zero_flag  out  1  registered flag, out_result == 0.
- retired  out  32  count of completed instructions.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  combinational reg[dbg_addr]; x0 reads 0.

## Operation
- Accept: in_valid && in_ready.
  - Operands are read, with forwarding, and the ALU evaluates combinationally.
  - At the accepting edge the WB register loads wb_valid=1, wb_rd=rd, wb_we=regwrite, wb_result=ALU output.
- Cycles with no accept: the WB register loads wb_valid=0. Other WB fields may hold.
- Writeback: while wb_valid && wb_we && wb_rd != 0, reg[wb_rd] is written at the end of that cycle.
- Register x0 reads 0 and is never written.
- alu_control encoding (A = operand A, B = operand B, sh = B[$clog2(XLEN)-1:0]):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR.
  - 0101 SLL by sh, 1000 SRL by sh, 1001 SRA by sh.
  - 0111 SLT (signed), 1010 SLTU. Both produce a zero-extended 0/1.
  - Any other code produces 0.
- Arithmetic is modulo 2^XLEN; carry and overflow are discarded.
- Hazard check: the in-flight WB entry is a hazard source when wb_valid && wb_we && wb_rd != 0. An operand matches it when:
  - rs1 == wb_rd, or
  - use_imm == 0 and rs2 == wb_rd.
- A same-cycle regfile write and read to the same address is resolved by the hazard path, never by regfile read-during-write.
- retired increments by 1 on every cycle with wb_valid=1 and wraps at 2^32. It counts completions regardless of wb_we.

## Timing
- Reset (reset==0 at a rising edge):
  - All registers become 0: regfile, WB fields, retired.
  - out_valid=0, out_result=0, zero_flag=0.
  - in_ready is 0 while reset is low.
- Reset asserted mid-operation: the in-flight WB entry is discarded, with no regfile write and no retire.
- Latency: an instruction accepted in cycle N gives out_valid=1 in cycle N+1. Its register write commits at the end of N+1.
- Throughput: one instruction per cycle with forwarding enabled.
- There is no output backpressure. out_valid is a pulse, and out_result and zero_flag hold until the next completion.
- in_ready is combinational from rs1, rs2, use_imm and the WB state. Issue logic must not make in_valid depend on in_ready.
- When in_valid=0, in_ready is still driven. A drop of in_ready does not affect an instruction that is not presented.
- Dependent instructions two or more cycles apart read the regfile directly.

## Configuration
- DATAPATH_BYPASS_EN defined:
  - A matching operand takes wb_result instead of the regfile.
  - in_ready = 1 whenever reset is deasserted.
- DATAPATH_BYPASS_EN undefined:
  - No forwarding path.
  - in_ready = 0 during any cycle with a hazard match; otherwise in_ready = 1.
  - The stalled instruction is accepted in the next cycle, after the write commits. This costs one bubble per dependent pair.
- Architectural results are identical in both builds; only timing differs.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release. Required: out_valid=0, retired=0, dbg_data=0 for every address, in_ready=1 in the first released cycle.
- Immediate ADD then SUB: issue x1=x0+5 (use_imm), then x2=x1-x1, in consecutive cycles.
  - With bypass: both accepted back-to-back; out_result 5 then 0; zero_flag 0 then 1; retired=2.
  - Without bypass: in_ready=0 for exactly one cycle before the second instruction.
- Shifts and compares, with x3=0x80000000 (XLEN=32):
  - SRA by imm 4 → 0xF8000000; SRL by 4 → 0x08000000.
  - SLT x3 < 1 → 1; SLTU x3 < 1 → 0.
  - Shift by imm 33 behaves as shift by 1.
- x0 protection: issue rd=0, x0+7, regwrite=1. Required: out_result=7, dbg_data at address 0 = 0, a following x0+x0 gives 0, and no stall in the no-bypass build.
- Reset mid-flight: accept x4=x0+9, then assert reset in the next cycle. Required: after release, dbg_data at address 4 = 0 and retired=0.
- Counter and use_imm: 10 back-to-back ADDs with regwrite=0 → retired=10. A dependency only on rs2 while use_imm=1 causes no stall in the no-bypass build.
